// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ==========================================================================
// uart_tx_fifo_if : core-side request/response bundle for the UART window
// Rev 1.0
// ==========================================================================
interface uart_tx_fifo_if;
  logic        uart_valid;
  logic        uart_instr;
  logic [31:0] uart_addr;
  logic [31:0] uart_wdata;
  logic [3:0]  uart_wstrb;
  logic [31:0] uart_rdata;
  logic        uart_ready;

  modport master (
    output uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb,
    input  uart_rdata, uart_ready
  );

  modport slave (
    input  uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb,
    output uart_rdata, uart_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ==========================================================================
// uart_tx_fifo : bus-mapped 8N1 UART transmitter with a byte FIFO
// Rev 1.0
// ==========================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 867,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  uart_tx_fifo_if.slave bus,
  output logic          uart_tx
);

  localparam int C_PTR_W  = $clog2(BUFFER_DEPTH);
  localparam int C_CNT_W  = C_PTR_W + 1;
  localparam int C_BAUD_W = (CLKS_PER_BIT < 1) ? 1 : $clog2(CLKS_PER_BIT + 1);
  localparam logic [C_CNT_W-1:0]  C_DEPTH    = C_CNT_W'(BUFFER_DEPTH);
  localparam logic [C_BAUD_W-1:0] C_BAUD_MAX = C_BAUD_W'(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_q,  state_d;
  logic [C_BAUD_W-1:0]  baud_q,   baud_d;
  logic [2:0]           bit_q,    bit_d;
  logic [7:0]           shift_q,  shift_d;
  logic                 tx_q,     tx_d;
  logic                 ready_q,  ready_d;
  logic [31:0]          rdata_q,  rdata_d;
  logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [C_CNT_W-1:0]   count_q,  count_d;
  logic [7:0]           mem_q [BUFFER_DEPTH];
  logic [7:0]           mem_d [BUFFER_DEPTH];

  logic w_push;
  logic w_pop;
  logic w_fifo_empty;
  logic w_fifo_full;
  logic w_baud_end;
  logic w_unused_bus;

  // The bus decoder already selects this window; only offset 0 exists.
  assign w_unused_bus = ^{bus.uart_instr, bus.uart_addr, bus.uart_wdata[31:8]};

  assign w_fifo_empty = (count_q == '0);
  assign w_fifo_full  = (count_q == C_DEPTH);
  assign w_baud_end   = (baud_q == C_BAUD_MAX);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    ready_d  = 1'b0;
    rdata_d  = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    w_push   = 1'b0;
    w_pop    = 1'b0;

    // A request is not serviced in the cycle its completion is presented.
    if (bus.uart_valid && !ready_q) begin
      if (bus.uart_wstrb == 4'b0000) begin
        ready_d = 1'b1;
        rdata_d = {30'd0, (w_fifo_empty && (state_q == S_IDLE)), w_fifo_full};
      end else if (!bus.uart_wstrb[0]) begin
        ready_d = 1'b1;
      end else if (!w_fifo_full) begin
        w_push  = 1'b1;
        ready_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!w_fifo_empty) begin
          w_pop   = 1'b1;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!w_fifo_empty) begin
            w_pop   = 1'b1;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    if (w_pop) begin
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (w_push) begin
      mem_d[wr_ptr_q] = bus.uart_wdata[7:0];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b0;
      rdata_q  <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: 8'd0};
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.uart_ready = ready_q;
  assign bus.uart_rdata = rdata_q;
  assign uart_tx        = tx_q;

endmodule
`default_nettype wire
